// File: rtl/y86_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 encodings: icodes, ALU ops, condition functions, CC layout.
// Revision: 1.0
// ---------------------------------------------------------------------------
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // rrmovq / cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU operations (match the OPq ifun encoding)
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  // Condition functions for cmovXX / jXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Stack pointer adjustment for call/ret/push/pop
  localparam logic [63:0] STACK_STEP = 64'd8;

  // Condition-code register layout: {ZF,SF,OF}
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Evaluate a branch/move condition against a set of flags
  function automatic logic cond_eval(input cc_t flags, input logic [3:0] fn);
    logic lt;
    lt = flags.sf ^ flags.of;
    case (fn)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | flags.zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = flags.zf;
      C_NE:    cond_eval = ~flags.zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~flags.zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// execute_if
// Bundle between the D/E pipeline register, the execute stage and memory.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface execute_if;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        cnd;
  logic [63:0] valE;
  logic [2:0]  cc;

  // Upstream side: supplies the decoded instruction, observes the results
  modport master (
    output icode, ifun, valA, valB, valC,
    input  cnd, valE, cc
  );

  // Execute stage side
  modport slave (
    input  icode, ifun, valA, valB, valC,
    output cnd, valE, cc
  );
endinterface
`default_nettype wire

// File: rtl/execute_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu
// Combinational 64-bit Y86-64 ALU: result = aluB <op> aluA, plus flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu
  import y86_pkg::*;
(
  input  logic [63:0] aluA_i,
  input  logic [63:0] aluB_i,
  input  alu_op_e     alufun_i,
  output logic [63:0] result_o,
  output logic        zf_o,
  output logic        sf_o,
  output logic        of_o
);

  logic [63:0] res_w;
  logic        of_w;

  // Operation select and signed-overflow detection from operand/result signs
  always_comb begin
    res_w = '0;
    of_w  = 1'b0;
    case (alufun_i)
      ALU_ADD: begin
        res_w = aluB_i + aluA_i;
        of_w  = (aluA_i[63] == aluB_i[63]) && (res_w[63] != aluA_i[63]);
      end
      ALU_SUB: begin
        res_w = aluB_i - aluA_i;
        of_w  = (aluA_i[63] != aluB_i[63]) && (res_w[63] != aluB_i[63]);
      end
      ALU_AND: res_w = aluB_i & aluA_i;
      ALU_XOR: res_w = aluB_i ^ aluA_i;
      default: res_w = '0;
    endcase
  end

  assign result_o = res_w;
  assign zf_o     = (res_w == 64'd0);
  assign sf_o     = res_w[63];
  assign of_o     = of_w;

endmodule
`default_nettype wire

// File: rtl/execute.sv
`default_nettype none
// ---------------------------------------------------------------------------
// execute
// Y86-64 Execute stage: operand muxing into the ALU, valE, the condition-code
// register and the cmov/jump condition.
// Revision: 1.0
// ---------------------------------------------------------------------------
module execute
  import y86_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  execute_if.slave ex
);

  logic [63:0] alu_a_w;
  logic [63:0] alu_b_w;
  alu_op_e     alufun_w;
  logic        res_valid_w;
  logic [63:0] alu_res_w;
  logic        zf_w;
  logic        sf_w;
  logic        of_w;
  logic        set_cc_w;
  cc_t         cc_q;
  cc_t         cc_d;

  // Route operands and pick the ALU function by instruction class
  always_comb begin
    alu_a_w     = '0;
    alu_b_w     = '0;
    alufun_w    = ALU_ADD;
    res_valid_w = 1'b0;
    case (ex.icode)
      I_RRMOVQ: begin
        alu_a_w     = ex.valA;
        res_valid_w = 1'b1;
      end
      I_IRMOVQ: begin
        alu_a_w     = ex.valC;
        res_valid_w = 1'b1;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a_w     = ex.valC;
        alu_b_w     = ex.valB;
        res_valid_w = 1'b1;
      end
      I_OPQ: begin
        alu_a_w     = ex.valA;
        alu_b_w     = ex.valB;
        alufun_w    = alu_op_e'(ex.ifun[1:0]);
        // Unknown OPq functions produce zero rather than an aliased op
        res_valid_w = (ex.ifun[3:2] == 2'b00);
      end
      I_CALL, I_PUSHQ: begin
        alu_a_w     = STACK_STEP;
        alu_b_w     = ex.valB;
        alufun_w    = ALU_SUB;
        res_valid_w = 1'b1;
      end
      I_RET, I_POPQ: begin
        alu_a_w     = STACK_STEP;
        alu_b_w     = ex.valB;
        res_valid_w = 1'b1;
      end
      default: res_valid_w = 1'b0;
    endcase
  end

  alu u_alu (
    .aluA_i   (alu_a_w),
    .aluB_i   (alu_b_w),
    .alufun_i (alufun_w),
    .result_o (alu_res_w),
    .zf_o     (zf_w),
    .sf_o     (sf_w),
    .of_o     (of_w)
  );

  assign set_cc_w = (ex.icode == I_OPQ) && (ex.ifun <= 4'd3);
  assign ex.valE  = res_valid_w ? alu_res_w : 64'd0;

  // Next CC value: only a valid OPq replaces the flags
  always_comb begin
    cc_d = cc_q;
    if (set_cc_w) begin
      cc_d = '{zf: zf_w, sf: sf_w, of: of_w};
    end
  end

  // CC register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= '0;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign ex.cc  = cc_q;
  // Condition uses the registered flags, so an OPq affects the following cycle
  assign ex.cnd = ((ex.icode == I_RRMOVQ) || (ex.icode == I_JXX))
                  ? cond_eval(cc_q, ex.ifun) : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_execute
// Self-checking bench for the execute stage against a behavioural model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_execute;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  execute_if ex_if ();

  execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] m_cc;   // model CC {ZF,SF,OF}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Reference behaviour, computed with widened signed arithmetic
  task automatic ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          output logic [63:0] e, output logic upd, output logic [2:0] fl);
    logic signed [64:0] wide;
    logic ovf;
    e = 64'd0; upd = 1'b0; fl = 3'b000; ovf = 1'b0;
    case (ic)
      4'h2: e = a;
      4'h3: e = c;
      4'h4, 4'h5: e = b + c;
      4'h6: begin
        upd = (fn <= 4'd3);
        case (fn)
          4'd0: begin wide = $signed({b[63], b}) + $signed({a[63], a}); e = wide[63:0]; ovf = wide[64] ^ wide[63]; end
          4'd1: begin wide = $signed({b[63], b}) - $signed({a[63], a}); e = wide[63:0]; ovf = wide[64] ^ wide[63]; end
          4'd2: e = b & a;
          4'd3: e = b ^ a;
          default: e = 64'd0;
        endcase
        fl = {(e == 64'd0), e[63], ovf};
      end
      4'h8, 4'hA: e = b - 64'd8;
      4'h9, 4'hB: e = b + 64'd8;
      default: e = 64'd0;
    endcase
  endtask

  function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] f);
    logic zf, sf, of;
    zf = f[2]; sf = f[1]; of = f[0];
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (sf ^ of) | zf;
      4'd2: return sf ^ of;
      4'd3: return zf;
      4'd4: return ~zf;
      4'd5: return ~(sf ^ of);
      4'd6: return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  // Present one instruction, check combinational outputs, then CC after the edge
  task automatic step(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [63:0] e; logic upd; logic [2:0] fl;
    @(negedge clk);
    ex_if.icode = ic; ex_if.ifun = fn; ex_if.valA = a; ex_if.valB = b; ex_if.valC = c;
    #1;
    ref_exec(ic, fn, a, b, c, e, upd, fl);
    check({tag, ".valE"}, ex_if.valE, e);
    check({tag, ".cnd"}, {63'd0, ex_if.cnd}, {63'd0, ref_cnd(ic, fn, m_cc)});
    @(posedge clk);
    if (rst_n && upd) m_cc = fl;
    #1;
    check({tag, ".cc"}, {61'd0, ex_if.cc}, {61'd0, m_cc});
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return {$urandom(), $urandom()};
      1: return 64'($signed($urandom_range(0, 200)) - 100);
      2: case ($urandom_range(0, 3))
           0: return 64'h7FFF_FFFF_FFFF_FFFF;
           1: return 64'h8000_0000_0000_0000;
           2: return 64'd0;
           default: return 64'hFFFF_FFFF_FFFF_FFFF;
         endcase
      default: return {32'd0, $urandom()};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    m_cc  = 3'b000;
    ex_if.icode = 4'h1; ex_if.ifun = 4'h0;
    ex_if.valA = '0; ex_if.valB = '0; ex_if.valC = '0;
    #3;
    check("reset.cc", {61'd0, ex_if.cc}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // ALU operations
    step("add", I_OPQ, 4'd0, 64'd20, -64'sd50, 64'd0);
    check("add.lit", ex_if.valE, -64'sd30);
    check("add.cclit", {61'd0, ex_if.cc}, 64'b010);
    step("sub", I_OPQ, 4'd1, -64'sd20, 64'd50, 64'd0);
    check("sub.lit", ex_if.valE, 64'd70);
    step("and", I_OPQ, 4'd2, 64'd50, 64'd50, 64'd0);
    check("and.lit", ex_if.valE, 64'd50);
    step("xor", I_OPQ, 4'd3, 64'd50, 64'd50, 64'd0);
    check("xor.cclit", {61'd0, ex_if.cc}, 64'b100);

    // Conditions with ZF set
    step("j0", I_JXX, 4'd0, 64'd0, 64'd0, 64'd0);
    check("j0.lit", {63'd0, ex_if.cnd}, 64'd1);
    step("j3", I_JXX, 4'd3, 64'd0, 64'd0, 64'd0);
    step("j4", I_JXX, 4'd4, 64'd0, 64'd0, 64'd0);
    check("j4.lit", {63'd0, ex_if.cnd}, 64'd0);
    step("j1", I_JXX, 4'd1, 64'd0, 64'd0, 64'd0);
    step("j6", I_JXX, 4'd6, 64'd0, 64'd0, 64'd0);
    step("cmov", I_RRMOVQ, 4'd0, -64'sd20, 64'd7, 64'd0);
    check("cmov.lit", ex_if.valE, -64'sd20);

    // Address and stack arithmetic
    step("irmov", I_IRMOVQ, 4'd0, 64'd0, 64'd0, -64'sd40);
    step("rmmov", I_RMMOVQ, 4'd0, 64'd0, -64'sd50, -64'sd80);
    check("rmmov.lit", ex_if.valE, -64'sd130);
    step("call", I_CALL, 4'd0, 64'd0, 64'd50, 64'd0);
    check("call.lit", ex_if.valE, 64'd42);
    step("ret", I_RET, 4'd0, 64'd0, 64'd50, 64'd0);
    check("ret.lit", ex_if.valE, 64'd58);
    step("push", I_PUSHQ, 4'd0, 64'd0, 64'd50, 64'd0);
    step("pop", I_POPQ, 4'd0, 64'd0, -64'sd50, 64'd0);
    check("pop.lit", ex_if.valE, -64'sd42);
    step("opbad", I_OPQ, 4'd5, 64'd3, 64'd4, 64'd0);

    // Overflow then asynchronous reset between edges
    step("ovf", I_OPQ, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check("ovf.cclit", {61'd0, ex_if.cc}, 64'b011);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async.cc", {61'd0, ex_if.cc}, 64'd0);
    m_cc = 3'b000;
    #1 rst_n = 1'b1;

    // Non-OPq leaves CC alone
    step("add2", I_OPQ, 4'd0, 64'd20, -64'sd50, 64'd0);
    step("hold", I_IRMOVQ, 4'd0, 64'd0, 64'd0, 64'd99);
    check("hold.cclit", {61'd0, ex_if.cc}, 64'b010);

    // Randomized instructions
    for (int i = 0; i < 300; i++) begin
      logic [3:0] ic, fn;
      ic = ($urandom_range(0, 3) == 0) ? I_OPQ : 4'($urandom_range(0, 15));
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      step("rnd", ic, fn, rnd_val(), rnd_val(), rnd_val());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
